// File: rtl/rom_pkg.sv
// Shared defaults and FSM state encoding for the sequential ROM reader.
package rom_pkg;
  localparam int ROM_WIDTH = 8;
  localparam int ROM_DEPTH = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;
endpackage

// File: rtl/rom_out_reg.sv
// Output word register with valid/ready handshake; load and accept may coincide.
module rom_out_reg #(
  parameter int WIDTH = rom_pkg::ROM_WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             capture,
  input  logic [WIDTH-1:0] d,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic             out_valid,
  output logic             accept,
  output logic             can_load
);
  assign accept   = out_valid && out_ready;
  // Register is free when empty or being drained this cycle, so stalls never bubble.
  assign can_load = !out_valid || out_ready;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_data  <= '0;
      out_valid <= 1'b0;
    end else if (capture) begin
      out_data  <= d;
      out_valid <= 1'b1;
    end else if (accept) begin
      out_valid <= 1'b0;
    end
  end
endmodule

// File: rtl/rom_seq_reader.sv
// Burst reader: walks an external combinational ROM from start_addr for len words.
module rom_seq_reader
  import rom_pkg::*;
#(
  parameter int WIDTH = ROM_WIDTH,
  parameter int DEPTH = ROM_DEPTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [DEPTH-1:0] start_addr,
  input  logic [DEPTH:0]   len,
  output logic [DEPTH-1:0] a,
  input  logic [WIDTH-1:0] q,
  output logic [WIDTH-1:0] out_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             busy,
  output logic             done
);
  localparam int CW = DEPTH + 1;
  localparam logic [CW-1:0] MAX_LEN = CW'(2 ** DEPTH);

  state_t        state, state_nx;
  logic [CW-1:0] len_q, iss_cnt, acc_cnt, acc_nx;
  logic          cap, acc, can_load;

  assign cap    = (state == RUN) && (iss_cnt < len_q) && can_load;
  // Completion looks at the count including this cycle's accept so done follows the last word.
  assign acc_nx = acc_cnt + CW'(acc);
  assign busy   = (state != IDLE);
  assign done   = (state == DONE);

  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (start) state_nx = RUN;
      RUN:     if (acc_nx == len_q) state_nx = DONE;
      DONE:    state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= IDLE;
      a       <= '0;
      len_q   <= '0;
      iss_cnt <= '0;
      acc_cnt <= '0;
    end else begin
      state <= state_nx;
      if (state == IDLE && start) begin
        a       <= start_addr;
        len_q   <= (len > MAX_LEN) ? MAX_LEN : len;
        iss_cnt <= '0;
        acc_cnt <= '0;
      end else begin
        if (cap) begin
          a       <= a + DEPTH'(1);
          iss_cnt <= iss_cnt + CW'(1);
        end
        if (acc) acc_cnt <= acc_nx;
      end
    end
  end

  rom_out_reg #(.WIDTH(WIDTH)) u_out (
    .clk      (clk),
    .rst      (rst),
    .capture  (cap),
    .d        (q),
    .out_ready(out_ready),
    .out_data (out_data),
    .out_valid(out_valid),
    .accept   (acc),
    .can_load (can_load)
  );
endmodule

// File: tb/tb_rom_seq_reader.sv
// Bench for rom_seq_reader: ROM word n = n+1, per-cycle traces checked against an expected word list.
module tb_rom_seq_reader;
  logic       clk, rst, start, out_ready;
  logic [3:0] start_addr, a;
  logic [4:0] len;
  logic [7:0] q, out_data;
  logic       out_valid, busy, done;

  int total = 0;
  int bad   = 0;

  logic [63:0] tv, tr, tdn, tbz;
  logic [7:0]  td[64];
  logic [3:0]  ta[64];

  assign q = 8'(a) + 8'd1;

  rom_seq_reader #(.WIDTH(8), .DEPTH(4)) dut (
    .clk(clk), .rst(rst), .start(start), .start_addr(start_addr), .len(len),
    .a(a), .q(q), .out_data(out_data), .out_valid(out_valid),
    .out_ready(out_ready), .busy(busy), .done(done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Cycle 0 is the start cycle; signals sampled mid-cycle on the falling edge.
  task automatic run_trace(input logic [3:0] sa, input logic [4:0] ln, input logic [63:0] rdy,
                           input int restart, input int ncyc);
    for (int c = 0; c < ncyc; c++) begin
      start      = (c == 0) || (c == restart);
      start_addr = (c == 0) ? sa : ~sa;
      len        = (c == 0) ? ln : 5'd3;
      out_ready  = rdy[c];
      @(negedge clk);
      tv[c] = out_valid; tr[c] = out_ready; tdn[c] = done; tbz[c] = busy;
      td[c] = out_data;  ta[c] = a;
      tick();
    end
    start     = 1'b0;
    out_ready = 1'b1;
  endtask

  task automatic check_trace(input string tag, input logic [3:0] sa, input logic [4:0] ln,
                             input int ncyc, input int exp_done);
    logic [7:0] exp_q[$];
    logic [7:0] got_q[$];
    int n, dn, dc, m;
    dn = 0; dc = 0;
    n = (ln > 5'd16) ? 16 : int'(ln);
    for (int i = 0; i < n; i++) exp_q.push_back(8'(((int'(sa) + i) % 16) + 1));
    for (int c = 0; c < ncyc; c++) begin
      if (tv[c] && tr[c]) got_q.push_back(td[c]);
      if (tdn[c]) begin dn++; dc = c; end
    end
    chk({tag, "_idle_busy"}, 32'(tbz[0]), 0);
    chk({tag, "_count"}, got_q.size(), exp_q.size());
    m = (got_q.size() < exp_q.size()) ? got_q.size() : exp_q.size();
    for (int i = 0; i < m; i++) chk({tag, "_word"}, 32'(got_q[i]), 32'(exp_q[i]));
    chk({tag, "_done_n"}, dn, 1);
    chk({tag, "_done_busy"}, 32'(tbz[dc]), 1);
    if (dc + 1 < ncyc) chk({tag, "_idle_after"}, 32'(tbz[dc + 1]), 0);
    if (exp_done >= 0) chk({tag, "_done_cyc"}, dc, exp_done);
  endtask

  initial begin
    logic [63:0] rdy;
    logic [3:0]  rsa;
    logic [4:0]  rln;
    rst = 1'b1; start = 1'b0; start_addr = '0; len = '0; out_ready = 1'b1;
    tick(); tick();
    chk("rst_valid", 32'(out_valid), 0);
    chk("rst_busy",  32'(busy), 0);
    chk("rst_done",  32'(done), 0);
    chk("rst_a",     32'(a), 0);
    chk("rst_data",  32'(out_data), 0);
    rst = 1'b0;
    tick();

    // Basic burst, ready always high
    run_trace(4'd0, 5'd4, '1, -1, 10);
    chk("b1_a_c1", 32'(ta[1]), 0);
    chk("b1_nv_c1", 32'(tv[1]), 0);
    for (int c = 2; c <= 5; c++) begin
      chk("b1_valid", 32'(tv[c]), 1);
      chk("b1_data", 32'(td[c]), c - 1);
    end
    check_trace("b1", 4'd0, 5'd4, 10, 6);

    // Address wrap
    run_trace(4'd14, 5'd4, '1, -1, 10);
    chk("wrap_a_c2", 32'(ta[2]), 15);
    chk("wrap_a_c3", 32'(ta[3]), 0);
    check_trace("wrap", 4'd14, 5'd4, 10, 6);

    // Back-pressure cycles 3..5
    rdy = '1; rdy[5:3] = 3'b000;
    run_trace(4'd0, 5'd4, rdy, -1, 12);
    for (int c = 3; c <= 5; c++) begin
      chk("bp_hold_data", 32'(td[c]), 2);
      chk("bp_hold_a", 32'(ta[c]), 2);
    end
    check_trace("bp", 4'd0, 5'd4, 12, 9);

    // Zero length
    run_trace(4'd7, 5'd0, '1, -1, 6);
    chk("len0_valid", 32'(|tv[5:0]), 0);
    check_trace("len0", 4'd7, 5'd0, 6, 2);

    // Over-length clamps to 16
    run_trace(4'd3, 5'd20, '1, -1, 22);
    check_trace("len20", 4'd3, 5'd20, 22, 18);

    // Start while busy ignored
    run_trace(4'd0, 5'd4, '1, 3, 10);
    check_trace("restart", 4'd0, 5'd4, 10, 6);
    chk("restart_idle", 32'(tbz[8]), 0);

    // Asynchronous reset mid-burst
    start = 1'b1; start_addr = 4'd0; len = 5'd4;
    tick();
    start = 1'b0;
    tick(); tick();
    #2;
    chk("pre_rst_valid", 32'(out_valid), 1);
    rst = 1'b1;
    #1;
    chk("arst_valid", 32'(out_valid), 0);
    chk("arst_busy",  32'(busy), 0);
    chk("arst_a",     32'(a), 0);
    chk("arst_done",  32'(done), 0);
    tick();
    rst = 1'b0;
    tick();
    run_trace(4'd5, 5'd3, '1, -1, 8);
    check_trace("post_rst", 4'd5, 5'd3, 8, 5);

    // Random bursts with random back-pressure
    for (int k = 0; k < 20; k++) begin
      rsa = 4'($urandom);
      rln = 5'($urandom_range(0, 20));
      rdy = {32'($urandom), 32'($urandom)};
      rdy[63:24] = '1;
      run_trace(rsa, rln, rdy, -1, 64);
      check_trace("rnd", rsa, rln, 64, -1);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
